// File: rtl/ext_code_seq_param_if.sv
// Host/trigger bus for the external-code sequencer: table load, index control,
// trigger input and the channel outputs that follow the trigger.
interface ext_code_seq_param_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
);
    logic             iWrEn;
    logic [IDX_W-1:0] iWrAddr;
    logic [WIDTH-1:0] iWrData;
    logic             iLoadIdx;
    logic [IDX_W-1:0] iLoadVal;
    logic [1:0]       iMode;
    logic             iTrigger;
    logic [WIDTH-1:0] oCode;
    logic [IDX_W-1:0] oIndex;
    logic             oActive;
    logic             oDone;

    // Strobes (iWrEn, iLoadIdx) act on every clock they are high; there is no
    // back-pressure. iTrigger is level-sensitive and may be fully asynchronous.
    modport master (
        output iWrEn, iWrAddr, iWrData, iLoadIdx, iLoadVal, iMode, iTrigger,
        input  oCode, oIndex, oActive, oDone
    );

    modport slave (
        input  iWrEn, iWrAddr, iWrData, iLoadIdx, iLoadVal, iMode, iTrigger,
        output oCode, oIndex, oActive, oDone
    );
endinterface

// File: rtl/ext_code_seq_param.sv
// External-code sequencer: a host-loaded code table stepped by external trigger
// pulses; the current code is driven only while a pulse is being served.
module ext_code_seq_param #(
    parameter int WIDTH       = 32,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input logic                iClk,
    input logic                iRst,
    ext_code_seq_param_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   trg_s_q;
    logic                   armed_q;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       code_q, code_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   pend_q, pend_d;

    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   at_end;
    logic [IDX_W-1:0]       idx_next;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // fill_q marks when the chain holds real samples; the detector only arms
    // once the trigger has been seen low, so a trigger held high through reset
    // never looks like a new rise.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            trg_s_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.iTrigger};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            trg_s_q <= sync_out;
            if (fill_q[SYNC_STAGES-1] && !sync_out) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise = armed_q && sync_out && !trg_s_q;
    assign fall = trg_s_q && !sync_out;

    // Table has no reset; nonblocking write gives read-before-write on capture.
    always_ff @(posedge iClk) begin
        if (bus.iWrEn) begin
            mem_q[bus.iWrAddr] <= bus.iWrData;
        end
    end

    assign at_end   = bus.iMode[0] ? (idx_q == '1) : (idx_q == '0);
    assign idx_next = bus.iMode[0] ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ACTIVE;
                    code_d  = mem_q[idx_q];
                    pend_d  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                    pend_d  = 1'b0;
                    if (pend_q) begin
                        if (at_end && bus.iMode[1]) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_next;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // An index load overrides any step and cancels the advance owed by a pulse.
        if (bus.iLoadIdx) begin
            idx_d  = bus.iLoadVal;
            pend_d = 1'b0;
            if (state_d == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign bus.oCode   = code_q;
    assign bus.oIndex  = idx_q;
    assign bus.oActive = (state_q == ST_ACTIVE);
    assign bus.oDone   = (state_q == ST_DONE);
endmodule
